// File: rtl/lsu_pkg.sv
// ============================================================================
// Package : lsu_pkg
// Brief   : Shared funct3, size and state encodings for the load/store unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // RISC-V funct3 values for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=00.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF && addr_lo[0]) begin
      mis = 1'b1;
    end
    if (size == SZ_WORD && addr_lo != 2'b00) begin
      mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Interface : load_store_unit_if
// Brief     : Execute request, memory port and writeback response bundle.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int RD_W   = 5,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic              mem_load;
  logic              mem_store;
  logic [1:0]        mem_size;
  logic              mem_signext;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [RD_W-1:0]   resp_rd;
  logic              resp_wb;
  logic              resp_err;

  // LSU side
  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_load, mem_store, mem_size, mem_signext, mem_addr, mem_din,
    input  mem_dout,
    output resp_valid, resp_data, resp_rd, resp_wb, resp_err,
    input  resp_ready
  );

  // Execute / memory / writeback side
  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_load, mem_store, mem_size, mem_signext, mem_addr, mem_din,
    output mem_dout,
    input  resp_valid, resp_data, resp_rd, resp_wb, resp_err,
    output resp_ready
  );

endinterface

`default_nettype wire

// File: rtl/lsu_decode.sv
// ============================================================================
// Module : lsu_decode
// Brief  : funct3/direction to size, sign-extend and illegal flag.
//          LSU_MISALIGN_CHECK_EN adds an alignment fault on half/word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_decode
  import lsu_pkg::*;
(
  input  logic       load,
  input  logic       store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [1:0] size,
  output logic       signext,
  output logic       illegal
);

  logic [1:0] w_size;
  logic       w_signext;
  logic       w_bad_op;

  always_comb begin
    w_size    = SZ_BYTE;
    w_signext = 1'b0;
    w_bad_op  = 1'b0;
    if (load && !store) begin
      case (funct3)
        F3_B:    begin w_size = SZ_BYTE; w_signext = 1'b1; end
        F3_H:    begin w_size = SZ_HALF; w_signext = 1'b1; end
        F3_W:    begin w_size = SZ_WORD; end
        F3_BU:   begin w_size = SZ_BYTE; end
        F3_HU:   begin w_size = SZ_HALF; end
        default: w_bad_op = 1'b1;
      endcase
    end else if (store && !load) begin
      case (funct3)
        F3_B:    w_size = SZ_BYTE;
        F3_H:    w_size = SZ_HALF;
        F3_W:    w_size = SZ_WORD;
        default: w_bad_op = 1'b1;
      endcase
    end else begin
      w_bad_op = 1'b1;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign illegal = w_bad_op | is_misaligned(w_size, addr_lo);
`else
  // Byte-addressed memory handles any alignment, so the low bits are not inspected.
  logic w_unused_addr;
  assign w_unused_addr = ^addr_lo;
  assign illegal       = w_bad_op;
`endif

  assign size    = w_size;
  assign signext = w_signext;

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Single-outstanding LSU: IDLE -> ISSUE -> (CAPTURE) -> RESP.
//          Optional LSU_MISALIGN_CHECK_EN faults misaligned half/word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               arst,
  load_store_unit_if.slave   bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;

  logic [1:0]        w_dec_size;
  logic              w_dec_signext;
  logic              w_dec_illegal;

  logic              r_mem_load;
  logic              r_mem_store;
  logic [1:0]        r_mem_size;
  logic              r_mem_signext;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_din;

  logic [31:0]       r_resp_data;
  logic [RD_W-1:0]   r_resp_rd;
  logic              r_resp_wb;
  logic              r_resp_err;

  lsu_decode u_decode (
    .load    (bus.req_load),
    .store   (bus.req_store),
    .funct3  (bus.req_funct3),
    .addr_lo (bus.req_addr[1:0]),
    .size    (w_dec_size),
    .signext (w_dec_signext),
    .illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = w_dec_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE:   w_next = r_mem_load ? ST_CAPTURE : ST_RESP;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // Memory controls default to zero each cycle, so they are live only during ISSUE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_mem_load    <= 1'b0;
      r_mem_store   <= 1'b0;
      r_mem_size    <= SZ_BYTE;
      r_mem_signext <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_resp_data   <= '0;
      r_resp_rd     <= '0;
      r_resp_wb     <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      r_mem_load    <= 1'b0;
      r_mem_store   <= 1'b0;
      r_mem_size    <= SZ_BYTE;
      r_mem_signext <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_resp_rd <= bus.req_rd;
            if (w_dec_illegal) begin
              r_resp_err  <= 1'b1;
              r_resp_wb   <= 1'b0;
              r_resp_data <= 32'(bus.req_addr);
            end else begin
              r_mem_load    <= bus.req_load;
              r_mem_store   <= bus.req_store;
              r_mem_size    <= w_dec_size;
              r_mem_signext <= w_dec_signext;
              r_mem_addr    <= bus.req_addr;
              r_mem_din     <= bus.req_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (r_mem_store) begin
            r_resp_data <= '0;
            r_resp_wb   <= 1'b0;
            r_resp_err  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          r_resp_data <= bus.mem_dout;
          r_resp_wb   <= 1'b1;
          r_resp_err  <= 1'b0;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_data <= '0;
            r_resp_rd   <= '0;
            r_resp_wb   <= 1'b0;
            r_resp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.resp_valid  = (r_state == ST_RESP);

  assign bus.mem_load    = r_mem_load;
  assign bus.mem_store   = r_mem_store;
  assign bus.mem_size    = r_mem_size;
  assign bus.mem_signext = r_mem_signext;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_din     = r_mem_din;

  assign bus.resp_data   = r_resp_data;
  assign bus.resp_rd     = r_resp_rd;
  assign bus.resp_wb     = r_resp_wb;
  assign bus.resp_err    = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed vector bench for load_store_unit with a byte memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int RD_W   = 5;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  load_store_unit_if #(.RD_W(RD_W), .ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.RD_W(RD_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int n_ld   = 0;
  int n_st   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Little-endian byte memory; registered read with size/sign handling.
  logic [7:0] mem [256];

  function automatic logic [31:0] mem_rd(input logic [7:0] a, input logic [1:0] sz, input logic se);
    logic [31:0] w;
    w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    case (sz)
      2'b00:   return se ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      2'b01:   return se ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] a;
    a = bus.mem_addr[7:0];
    if (bus.mem_load) bus.mem_dout <= mem_rd(a, bus.mem_size, bus.mem_signext);
    if (bus.mem_store) begin
      case (bus.mem_size)
        2'b00: mem[a] <= bus.mem_din[7:0];
        2'b01: begin
          mem[a]         <= bus.mem_din[7:0];
          mem[a + 8'd1]  <= bus.mem_din[15:8];
        end
        default: begin
          mem[a]         <= bus.mem_din[7:0];
          mem[a + 8'd1]  <= bus.mem_din[15:8];
          mem[a + 8'd2]  <= bus.mem_din[23:16];
          mem[a + 8'd3]  <= bus.mem_din[31:24];
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.mem_load)  n_ld++;
    if (bus.mem_store) n_st++;
  end

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        err;
    logic        wb;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string name, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input logic err, input logic wb, input logic [31:0] data, input int lat);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.err = err; v.wb = wb; v.data = data; v.lat = lat;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_load   = v.ld;
    bus.req_store  = v.st;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
  endtask

  task automatic idle_req();
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
  endtask

  // Latency k means resp_valid is first sampled high just before edge T+k.
  task automatic run_req(input vec_t v);
    int lat;
    int ld0, st0;
    @(negedge clk);
    check({v.name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    ld0 = n_ld;
    st0 = n_st;
    drive_req(v);
    @(posedge clk);
    #1 idle_req();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    if (lat != 0) begin
      check({v.name, " err"},  32'(bus.resp_err), 32'(v.err));
      check({v.name, " wb"},   32'(bus.resp_wb),  32'(v.wb));
      check({v.name, " data"}, bus.resp_data,     v.data);
      if (v.wb) check({v.name, " rd"}, 32'(bus.resp_rd), 32'(v.rd));
      check({v.name, " busy"}, 32'(bus.req_ready), 32'd0);
    end
    check({v.name, " load strobes"},  32'(n_ld - ld0), (!v.err && v.ld) ? 32'd1 : 32'd0);
    check({v.name, " store strobes"}, 32'(n_st - st0), (!v.err && v.st) ? 32'd1 : 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    int st0;
    int lat;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.mem_dout   = '0;
    bus.resp_ready = 1'b0;
    idle_req();
    arst = 1'b1;

    //       name       ld st f3      addr   wdata         rd  err wb data          lat
    vt.push_back(mk("sw_beef",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 0, 0, 32'h0,        2));
    vt.push_back(mk("lw_beef",  1, 0, 3'b010, 32'h10, 32'h0,        5, 0, 1, 32'hDEADBEEF, 3));
    vt.push_back(mk("sw_8000",  0, 1, 3'b010, 32'h10, 32'h00008000, 0, 0, 0, 32'h0,        2));
    vt.push_back(mk("lb",       1, 0, 3'b000, 32'h11, 32'h0,        6, 0, 1, 32'hFFFFFF80, 3));
    vt.push_back(mk("lbu",      1, 0, 3'b100, 32'h11, 32'h0,        7, 0, 1, 32'h00000080, 3));
    vt.push_back(mk("lh",       1, 0, 3'b001, 32'h10, 32'h0,        8, 0, 1, 32'hFFFF8000, 3));
    vt.push_back(mk("lhu",      1, 0, 3'b101, 32'h10, 32'h0,       31, 0, 1, 32'h00008000, 3));
    vt.push_back(mk("ld_f3_3",  1, 0, 3'b011, 32'h20, 32'h0,        4, 1, 0, 32'h00000020, 1));
    vt.push_back(mk("st_f3_4",  0, 1, 3'b100, 32'h24, 32'h1234,     0, 1, 0, 32'h00000024, 1));
    vt.push_back(mk("both",     1, 1, 3'b010, 32'h30, 32'h0,        1, 1, 0, 32'h00000030, 1));
    vt.push_back(mk("neither",  0, 0, 3'b010, 32'h34, 32'h0,        1, 1, 0, 32'h00000034, 1));
    vt.push_back(mk("sb",       0, 1, 3'b000, 32'h41, 32'h000000A5, 0, 0, 0, 32'h0,        2));
    vt.push_back(mk("lbu_a5",   1, 0, 3'b100, 32'h41, 32'h0,        2, 0, 1, 32'h000000A5, 3));
    vt.push_back(mk("lw_a500",  1, 0, 3'b010, 32'h40, 32'h0,        2, 0, 1, 32'h0000A500, 3));
    vt.push_back(mk("sw_1122",  0, 1, 3'b010, 32'h14, 32'h11223344, 0, 0, 0, 32'h0,        2));
`ifdef LSU_MISALIGN_CHECK_EN
    vt.push_back(mk("lw_mis",   1, 0, 3'b010, 32'h12, 32'h0,       10, 1, 0, 32'h00000012, 1));
`else
    vt.push_back(mk("lw_mis",   1, 0, 3'b010, 32'h12, 32'h0,       10, 0, 1, 32'h33440000, 3));
`endif

    // Reset state
    #12;
    check("rst req_ready",  32'(bus.req_ready),   32'd1);
    check("rst mem_load",   32'(bus.mem_load),    32'd0);
    check("rst mem_store",  32'(bus.mem_store),   32'd0);
    check("rst mem_size",   32'(bus.mem_size),    32'd0);
    check("rst mem_signext",32'(bus.mem_signext), 32'd0);
    check("rst mem_addr",   bus.mem_addr,         32'd0);
    check("rst mem_din",    bus.mem_din,          32'd0);
    check("rst resp_valid", 32'(bus.resp_valid),  32'd0);
    check("rst resp_flags", {30'd0, bus.resp_wb, bus.resp_err}, 32'd0);
    check("rst resp_data",  bus.resp_data,        32'd0);
    check("rst resp_rd",    32'(bus.resp_rd),     32'd0);
    @(negedge clk);
    arst = 1'b0;

    foreach (vt[i]) run_req(vt[i]);

    // Back-pressure: response held, second request ignored
    @(negedge clk);
    drive_req(mk("bp", 1, 0, 3'b010, 32'h10, 32'h0, 9, 0, 1, 32'h0, 3));
    @(posedge clk);
    #1 idle_req();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    check("bp latency", 32'(lat), 32'd3);
    st0 = n_st;
    drive_req(mk("bp_sw", 0, 1, 3'b010, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 2));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp valid held", 32'(bus.resp_valid), 32'd1);
      check("bp data held",  bus.resp_data,       32'h00008000);
      check("bp rd held",    32'(bus.resp_rd),    32'd9);
      check("bp ready low",  32'(bus.req_ready),  32'd0);
    end
    idle_req();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("bp no store", 32'(n_st - st0), 32'd0);
    run_req(mk("bp_next", 1, 0, 3'b010, 32'h10, 32'h0, 11, 0, 1, 32'h00008000, 3));

    // Reset during ISSUE of a store
    @(negedge clk);
    drive_req(mk("rst_sw", 0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 0, 32'h0, 2));
    @(posedge clk);
    #1 idle_req();
    #1 check("mid issue strobe", 32'(bus.mem_store), 32'd1);
    arst = 1'b1;
    #1;
    check("mid rst mem_store",  32'(bus.mem_store),  32'd0);
    check("mid rst mem_addr",   bus.mem_addr,        32'd0);
    check("mid rst mem_din",    bus.mem_din,         32'd0);
    check("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid rst req_ready",  32'(bus.req_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    st0 = n_st;
    repeat (3) @(negedge clk);
    check("post rst no strobe", 32'(n_st - st0),     32'd0);
    check("post rst idle",      32'(bus.req_ready),  32'd1);
    check("post rst no resp",   32'(bus.resp_valid), 32'd0);
    run_req(mk("post_rst_lw", 1, 0, 3'b010, 32'h10, 32'h0, 12, 0, 1, 32'h00008000, 3));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access pipeline stage placed directly upstream of the byte-addressed data memory.
- Accepts one load/store request from execute over a valid/ready handshake and decodes RISC-V funct3 into memory size and sign-extension controls.
- Sequences the memory's one-cycle registered load, captures the result and presents it to writeback over a valid/ready handshake.
- Single outstanding request; non-pipelined.

Parameters:
- RD_W, 5, destination register index width.
- ADDR_W, 32, address width passed to memory.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- req_valid  in  1  execute request valid.
- req_ready  out  1  LSU can accept a request.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  RISC-V funct3.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data.
- req_rd  in  RD_W  load destination register.
- mem_load  out  1  memory load enable.
- mem_store  out  1  memory store enable.
- mem_size  out  2  00 byte, 01 half, 10 word.
- mem_signext  out  1  memory sign-extend select.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory registered read data.
- resp_valid  out  1  writeback response valid.
- resp_ready  in  1  writeback accepts response.
- resp_data  out  32  load data, or faulting address on error.
- resp_rd  out  RD_W  destination register.
- resp_wb  out  1  register write required (loads without error).
- resp_err  out  1  illegal or misaligned access.

Behaviour:
- Clock and reset: clk rising edge; arst asynchronous, active-high.
- Reset values:
  - State IDLE.
  - req_ready=1.
  - All mem_* outputs 0.
  - resp_valid, resp_wb, resp_err 0.
  - resp_data and resp_rd 0.
  - Reset mid-operation abandons the request; no memory strobe is emitted after reset deasserts.
- States:
  - IDLE: req_ready=1. On req_valid, latch request and decode. Legal request goes to ISSUE; illegal request goes straight to RESP with err=1.
  - ISSUE (1 cycle): mem_load or mem_store=1 with registered size, signext, addr and din. Load goes to CAPTURE; store goes to RESP.
  - CAPTURE (1 cycle): mem strobes 0; resp_data<=mem_dout on exit; goes to RESP.
  - RESP: resp_valid=1 and all resp_* held stable until resp_ready. Then return to IDLE. req_ready=0 in every state except IDLE.
- mem_* are registered outputs and are 0 outside ISSUE, so each memory strobe lasts exactly one cycle.
- Latency, with acceptance at edge T:
  - Load: resp_valid high from T+3.
  - Store: resp_valid high from T+2, memory written at edge T+2.
  - Illegal request: resp_valid high from T+1.
- Decode:
  - Loads: 000 byte/signext=1; 001 half/signext=1; 010 word; 100 byte/signext=0; 101 half/signext=0.
  - Stores: 000, 001, 010 only.
  - Every other funct3 is illegal, as are req_load==req_store (both or neither).
  - Illegal request: no memory access, resp_err=1, resp_wb=0, resp_data=req_addr.
- Store response: resp_wb=0, resp_err=0, resp_data=0.
- Address is passed unmodified; wrap-around is the memory's concern.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=00, is illegal.
  - Handled exactly as an illegal funct3: no memory strobe, err=1, resp_data=address, latency T+1.
- Undefined:
  - No alignment check; misaligned accesses are issued unchanged, since the memory is byte-addressed.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - 2-bit state encoding ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_RESP.
- One combinational sub-module, lsu_decode, maps (load, store, funct3, addr) to (size, signext, illegal). The misalignment check sits inside lsu_decode.

Test Plan:
1. LW, addr 0x010, after SW 0xDEADBEEF to 0x010 -> store resp at T+2 (wb=0). Load resp at T+3 with data 0xDEADBEEF, wb=1, rd echoed.
2. LB and LBU at 0x011 after SW 0x0000_8000 to 0x010 -> LB 0xFFFFFF80, LBU 0x00000080. LH and LHU at 0x010 -> 0xFFFF8000 and 0x00008000.
3. funct3=011 load at 0x020 -> resp at T+1 with err=1, data 0x00000020, wb=0; mem_load/mem_store never asserted.
4. resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0, second req_valid ignored. After resp_ready=1 the next request is accepted in IDLE.
5. arst pulsed during ISSUE of a SW -> all outputs 0 immediately; IDLE, req_ready=1 after release.
6. With LSU_MISALIGN_CHECK_EN: LW at 0x012 -> err=1, data 0x00000012, no strobe. Without the macro: strobe issued, err=0.
